// File: rtl/cpu_instr_feeder.sv
// cpu_instr_feeder: buffered instruction issuer for the cpu core's 8-bit input.
// A valid/ready FIFO collects instruction bytes. A slot FSM issues them one per
// clock, keeps an opcode and its operand adjacent, stretches hold-class opcodes
// to two cycles, and drives NOP_CODE whenever no complete instruction is ready.
module cpu_instr_feeder #(
    parameter int          DEPTH    = 16,
    parameter logic [7:0]  NOP_CODE = 8'hF0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       pause,
    output logic [7:0] cpu_in,
    output logic       busy,
    output logic [7:0] issued_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // State names the slot that cpu_in carries during the current cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP   = 2'd1,
        ST_DATA = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Opcode followed immediately by one data byte.
    function automatic logic is_operand_class(input logic [7:0] op);
        case (op[7:4])
            4'b0110, 4'b0111, 4'b1000: is_operand_class = 1'b1;
            default:                   is_operand_class = 1'b0;
        endcase
    endfunction

    // Opcode that must be driven for two consecutive cycles.
    function automatic logic is_hold_class(input logic [7:0] op);
        case (op[7:4])
            4'b1010, 4'b1100: is_hold_class = 1'b1;
            default:          is_hold_class = 1'b0;
        endcase
    endfunction

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [7:0]    cpu_in_q, cpu_in_d;
    logic [7:0]    issued_q, issued_d;

    logic          full_s;
    logic          push_s;
    logic          pop_s;
    logic          issue_s;
    logic          boundary_s;
    logic          can_issue_s;
    logic [7:0]    head_s;

    assign full_s  = (count_q == CW'(DEPTH));
    assign push_s  = s_valid && !full_s;
    assign head_s  = mem_q[rd_ptr_q];

    assign s_ready    = !full_s;
    assign cpu_in     = cpu_in_q;
    assign busy       = (state_q != ST_IDLE);
    assign issued_cnt = issued_q;

    // A new opcode may start only if unpaused and, for operand class, its operand is already buffered.
    always_comb begin
        can_issue_s = 1'b0;
        if (pause || (count_q == {CW{1'b0}})) begin
            can_issue_s = 1'b0;
        end else if (is_operand_class(head_s) && (count_q < CW'(2))) begin
            can_issue_s = 1'b0;
        end else begin
            can_issue_s = 1'b1;
        end
    end

    // Next-slot selection and the byte/pop/issue actions for that slot.
    always_comb begin
        state_d    = state_q;
        cpu_in_d   = cpu_in_q;
        pop_s      = 1'b0;
        issue_s    = 1'b0;
        boundary_s = 1'b0;

        case (state_q)
            ST_OP: begin
                if (is_operand_class(cpu_in_q)) begin
                    state_d = ST_DATA;
                end else if (is_hold_class(cpu_in_q)) begin
                    state_d = ST_HOLD;
                end else begin
                    boundary_s = 1'b1;
                end
            end
            ST_IDLE, ST_DATA, ST_HOLD: boundary_s = 1'b1;
            default:                   boundary_s = 1'b1;
        endcase

        if (boundary_s) begin
            if (can_issue_s) begin
                state_d = ST_OP;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            state_d = state_d;
        end

        case (state_d)
            ST_IDLE: cpu_in_d = NOP_CODE;
            ST_OP: begin
                cpu_in_d = head_s;
                pop_s    = 1'b1;
                issue_s  = 1'b1;
            end
            ST_DATA: begin
                cpu_in_d = head_s;
                pop_s    = 1'b1;
            end
            ST_HOLD: cpu_in_d = cpu_in_q;
            default: cpu_in_d = NOP_CODE;
        endcase
    end

    // FIFO pointer, occupancy and issue counter next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        issued_d = issued_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (issue_s) begin
            issued_d = issued_q + 8'd1;
        end else begin
            issued_d = issued_q;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            state_q  <= ST_IDLE;
            cpu_in_q <= NOP_CODE;
            issued_q <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            cpu_in_q <= cpu_in_d;
            issued_q <= issued_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

endmodule

// File: tb/tb_cpu_instr_feeder.sv
// Self-checking bench for cpu_instr_feeder: a scoreboard queue holds the bytes
// expected on cpu_in for every busy cycle, plus table-driven and hand sequences.
module tb_cpu_instr_feeder;

    localparam logic [7:0] NOP = 8'hF0;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       pause;
    logic [7:0] cpu_in;
    logic       busy;
    logic [7:0] issued_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_issued = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        logic [15:0] bytes;
        int          nb;
        logic [23:0] exp;
        int          ne;
        int          ni;
    } vec_t;

    vec_t tbl [8];

    cpu_instr_feeder #(.DEPTH(16), .NOP_CODE(8'hF0)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .pause      (pause),
        .cpu_in     (cpu_in),
        .busy       (busy),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
        end
    endtask

    // Scoreboard: every busy cycle must carry the next expected byte.
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%02h expected=none", cpu_in);
            end else begin
                check8("sb_cpu_in", cpu_in, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        s_data  = b;
        s_valid = 1'b1;
        check1("push_ready", s_ready, 1'b1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (n < maxc && (exp_q.size() != 0 || busy === 1'b1)) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || busy === 1'b1) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending expected=0_pending", exp_q.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{bytes:16'h2000, nb:1, exp:24'h200000, ne:1, ni:1};
        tbl[1] = '{bytes:16'h83FF, nb:2, exp:24'h83FF00, ne:2, ni:1};
        tbl[2] = '{bytes:16'hA3B0, nb:2, exp:24'hA3A3B0, ne:3, ni:2};
        tbl[3] = '{bytes:16'hC300, nb:1, exp:24'hC3C300, ne:2, ni:1};
        tbl[4] = '{bytes:16'h70A5, nb:2, exp:24'h70A500, ne:2, ni:1};
        tbl[5] = '{bytes:16'h6561, nb:2, exp:24'h656100, ne:2, ni:1};
        tbl[6] = '{bytes:16'h9F00, nb:1, exp:24'h9F0000, ne:1, ni:1};
        tbl[7] = '{bytes:16'hB0C1, nb:2, exp:24'hB0C1C1, ne:3, ni:2};

        // Reset and idle
        reset = 1'b1; s_valid = 1'b0; s_data = 8'h00; pause = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        check8("rst_cpu_in", cpu_in, NOP);
        check1("rst_busy", busy, 1'b0);
        check1("rst_ready", s_ready, 1'b1);
        check8("rst_issued", issued_cnt, 8'd0);

        // Two single-cycle opcodes pushed on consecutive edges issue with one-cycle latency
        exp_q.push_back(8'h20); exp_q.push_back(8'h30);
        push(8'h20);
        push(8'h30);
        @(negedge clk); check8("lat_first", cpu_in, 8'h20);
        @(negedge clk); check8("lat_second", cpu_in, 8'h30);
        @(negedge clk); check8("lat_nop", cpu_in, NOP);
        tick();
        exp_issued += 2;
        check8("lat_issued", issued_cnt, exp_issued[7:0]);

        // Operand opcode alone stalls until its operand is buffered
        exp_q.push_back(8'h83); exp_q.push_back(8'hFF);
        push(8'h83);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); check8("stall_nop", cpu_in, NOP);
        end
        tick();
        push(8'hFF);
        @(negedge clk); check8("stall_release_nop", cpu_in, NOP);
        @(negedge clk); check8("pair_opcode", cpu_in, 8'h83);
        @(negedge clk); check8("pair_operand", cpu_in, 8'hFF);
        tick();
        exp_issued += 1;
        drain(20);
        check8("pair_issued", issued_cnt, exp_issued[7:0]);

        // Table of instruction mixes
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < tbl[i].ne; k++) begin
                exp_q.push_back(tbl[i].exp[23 - 8*k -: 8]);
            end
            for (int j = 0; j < tbl[i].nb; j++) begin
                push(tbl[i].bytes[15 - 8*j -: 8]);
            end
            exp_issued += tbl[i].ni;
            drain(20);
            check8("tbl_issued", issued_cnt, exp_issued[7:0]);
            check8("tbl_idle", cpu_in, NOP);
        end

        // Fill under pause, then full with simultaneous pop
        pause = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            exp_q.push_back(8'(i));
        end
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
        end
        s_data = 8'h10; s_valid = 1'b1;
        check1("full_ready", s_ready, 1'b0);
        check8("pause_cpu_in", cpu_in, NOP);
        check1("pause_busy", busy, 1'b0);
        tick();
        check1("full_still", s_ready, 1'b0);
        pause = 1'b0;
        tick();
        check1("ready_after_pop", s_ready, 1'b1);
        check1("first_drain_busy", busy, 1'b1);
        tick();
        s_valid = 1'b0;
        begin
            int gaps = 0;
            for (int i = 0; i < 16; i++) begin
                if (busy !== 1'b1) gaps++;
                tick();
            end
            checks++;
            if (gaps != 0) begin
                failures++;
                $display("FAIL drain_gapless actual=%0d_gaps expected=0_gaps", gaps);
            end
        end
        exp_issued += 17;
        drain(20);
        check8("full_issued", issued_cnt, exp_issued[7:0]);

        // Stream enough opcodes to wrap the issue counter
        for (int i = 0; i < 250; i++) begin
            exp_q.push_back(8'h01);
        end
        for (int i = 0; i < 250; i++) begin
            push(8'h01);
        end
        exp_issued += 250;
        drain(40);
        check1("wrap_crossed", (exp_issued > 255) ? 1'b1 : 1'b0, 1'b1);
        check8("wrap_issued", issued_cnt, exp_issued[7:0]);

        // Reset while the operand opcode is on cpu_in
        exp_q.push_back(8'h60);
        push(8'h60);
        push(8'h05);
        begin
            int n = 0;
            while (n < 10 && cpu_in !== 8'h60) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (cpu_in !== 8'h60) begin
                failures++;
                $display("FAIL rst_wait actual=%02h expected=60", cpu_in);
            end
        end
        reset = 1'b1;
        tick();
        check8("mid_rst_cpu_in", cpu_in, NOP);
        check1("mid_rst_busy", busy, 1'b0);
        check8("mid_rst_issued", issued_cnt, 8'd0);
        check1("mid_rst_ready", s_ready, 1'b1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check8("post_rst_nop", cpu_in, NOP);
        end
        check1("post_rst_sb_empty", (exp_q.size() == 0) ? 1'b1 : 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
